// File: rtl/imm_rotate_encoder.sv
// Iterative 32-bit constant to {rotate_imm, immed_8} immediate encoder, one rotation per clock.
// Optional second pass on the inverted value when IMM_ENC_NEGATE_EN is defined.
module imm_rotate_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_ok,
  output logic [11:0] out_code,
  output logic        out_carry
`ifdef IMM_ENC_NEGATE_EN
  ,
  output logic        out_inverted
`endif
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] val;
  logic [3:0]  rot;
  logic [31:0] r;
  logic        hit;
  logic        accept, step, set_hit, set_miss;
`ifdef IMM_ENC_NEGATE_EN
  logic        inv;
  logic        flip;
`endif

  // Rotate-left by 2*rot undoes the shifter's rotate-right expansion.
  always_comb begin
    r   = (val << {rot, 1'b0}) | (val >> (6'd32 - {1'b0, rot, 1'b0}));
    hit = (r[31:8] == 24'd0);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    set_hit   = 1'b0;
    set_miss  = 1'b0;
`ifdef IMM_ENC_NEGATE_EN
    flip      = 1'b0;
`endif
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          set_hit   = 1'b1;
          state_nxt = DONE;
        end else if (rot != 4'd15) begin
          step = 1'b1;
`ifdef IMM_ENC_NEGATE_EN
        end else if (!inv) begin
          flip = 1'b1;
`endif
        end else begin
          set_miss  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rot       <= 4'd0;
      out_ok    <= 1'b0;
      out_code  <= 12'd0;
      out_carry <= 1'b0;
`ifdef IMM_ENC_NEGATE_EN
      inv          <= 1'b0;
      out_inverted <= 1'b0;
`endif
    end else begin
      if (accept) begin
        rot <= 4'd0;
`ifdef IMM_ENC_NEGATE_EN
        inv <= 1'b0;
      end else if (flip) begin
        rot <= 4'd0;
        inv <= 1'b1;
`endif
      end else if (step) begin
        rot <= rot + 4'd1;
      end
      if (set_hit) begin
        out_ok    <= 1'b1;
        out_code  <= {rot, r[7:0]};
        out_carry <= (rot != 4'd0) & val[31];
`ifdef IMM_ENC_NEGATE_EN
        out_inverted <= inv;
`endif
      end else if (set_miss) begin
        out_ok    <= 1'b0;
        out_code  <= 12'd0;
        out_carry <= 1'b0;
`ifdef IMM_ENC_NEGATE_EN
        out_inverted <= 1'b0;
`endif
      end
    end
  end

  // Search operand is data only; it is always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) val <= in_value;
`ifdef IMM_ENC_NEGATE_EN
    else if (flip) val <= ~val;
`endif
  end

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Directed bench for imm_rotate_encoder: encodings, latencies, back-pressure, reset mid-search.
// Honors IMM_ENC_NEGATE_EN the same way as the design.
module tb_imm_rotate_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic        out_ok;
  logic [11:0] out_code;
  logic        out_carry;
`ifdef IMM_ENC_NEGATE_EN
  logic        out_inverted;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_rotate_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ok    (out_ok),
    .out_code  (out_code),
    .out_carry (out_carry)
`ifdef IMM_ENC_NEGATE_EN
    ,
    .out_inverted (out_inverted)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a value, accept it, and wait (bounded) for out_valid; check result and latency.
  task automatic run(input string tag, input logic [31:0] v, input logic ok,
                     input logic [11:0] code, input logic carry, input int lat_exp);
    int lat;
    @(negedge clk);
    in_value = v;
    in_valid = 1'b1;
    #1 check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid) break;
    end
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_ok"},      {31'd0, out_ok}, {31'd0, ok});
    check({tag, "_code"},    {20'd0, out_code}, {20'd0, code});
    check({tag, "_carry"},   {31'd0, out_carry}, {31'd0, carry});
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_value  = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_ok",    {31'd0, out_ok}, 32'd0);
    check("rst_out_code",  {20'd0, out_code}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    run("rot0", 32'h0000_00FF, 1'b1, 12'h0FF, 1'b0, 1);
`ifdef IMM_ENC_NEGATE_EN
    check("rot0_inv", {31'd0, out_inverted}, 32'd0);
`endif
    release_out("rot0");

    run("rot2", 32'hF000_000F, 1'b1, 12'h2FF, 1'b1, 3);
    release_out("rot2");

    run("rot4", 32'hFF00_0000, 1'b1, 12'h4FF, 1'b1, 5);
    release_out("rot4");

`ifdef IMM_ENC_NEGATE_EN
    run("nocode", 32'h0000_0101, 1'b0, 12'h000, 1'b0, 32);
    check("nocode_inv", {31'd0, out_inverted}, 32'd0);
    release_out("nocode");

    run("negate", 32'hFFFF_FF00, 1'b1, 12'h0FF, 1'b0, 17);
    check("negate_inv", {31'd0, out_inverted}, 32'd1);
    release_out("negate");
`else
    run("nocode", 32'h0000_0101, 1'b0, 12'h000, 1'b0, 16);
    release_out("nocode");
`endif

    // Back-pressure: result must hold for 5 cycles with out_ready low.
    run("bp", 32'hF000_000F, 1'b1, 12'h2FF, 1'b1, 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_code",  {20'd0, out_code}, 32'h2FF);
    end
    // Back-to-back: next value waiting with in_valid high across the handshake.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_value  = 32'h0000_0004;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("b2b_valid_drop", {31'd0, out_valid}, 32'd0);
    check("b2b_in_ready",   {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("b2b_accepted",   {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("low_rot_valid",  {31'd0, out_valid}, 32'd1);
    check("low_rot_code",   {20'd0, out_code}, 32'h004);
    check("low_rot_carry",  {31'd0, out_carry}, 32'd0);
    release_out("low_rot");

    // Reset during the 8th SEARCH cycle of an unencodable value.
    @(negedge clk);
    in_value = 32'h0000_0101;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ok",    {31'd0, out_ok}, 32'd0);
    check("mid_rst_code",  {20'd0, out_code}, 32'd0);
    check("mid_rst_carry", {31'd0, out_carry}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    run("post_rst", 32'h0000_00FF, 1'b1, 12'h0FF, 1'b0, 1);
    release_out("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
